// File: rtl/pwl_transform_engine.sv
// Runtime-reprogrammable piecewise-linear transfer function: a pending M/C table, a
// sequential slope divider, atomic bank commit and a 3-stage mapping pipeline.
// Optional build macro PWL_ROUND_EN selects round-half-up in the final scaling shift.
module pwl_transform_engine #(
  parameter int DSIZE    = 12,
  parameter int DT_I     = 8,
  parameter int DT_D     = 4,
  parameter int SEG_LOG2 = 4
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                tbl_wr,
  input  logic [SEG_LOG2-1:0] tbl_addr,
  input  logic [DSIZE-1:0]    tbl_m,
  input  logic [DSIZE-1:0]    tbl_c,
  input  logic                cal_begin,
  output logic                cal_busy,
  output logic                cal_valid,
  input  logic                in_valid,
  input  logic [DSIZE-1:0]    indata,
  output logic                out_valid,
  output logic [DSIZE-1:0]    outdata
);

  localparam int NSEG = 1 << SEG_LOG2;
  localparam int Q    = DT_I + DT_D;
  localparam int RW   = DSIZE + Q;
  localparam int PW   = DSIZE + Q + 1;
  localparam int CW   = $clog2(Q);
  localparam logic signed [PW:0] SUM_MAX = (PW+1)'((1 << DSIZE) - 1);
`ifdef PWL_ROUND_EN
  localparam logic signed [PW:0] RND = (PW+1)'(1 << (DT_D - 1));
`else
  localparam logic signed [PW:0] RND = '0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_COMMIT} state_e;

  state_e                state_q, state_d;
  logic [SEG_LOG2-1:0]   idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RW-1:0]         rem_q, rem_d, dv_q, dv_d;
  logic [Q-2:0]          quo_q, quo_d;
  logic                  neg_q, neg_d, dpos_q, dpos_d;
  logic                  cal_valid_q, cal_valid_d;

  logic [DSIZE-1:0]      m_p_q [NSEG];
  logic [DSIZE-1:0]      c_p_q [NSEG];
  logic signed [Q-1:0]   slope_p_q [NSEG];
  logic [DSIZE-1:0]      m_a_q [NSEG];
  logic [DSIZE-1:0]      c_a_q [NSEG];
  logic signed [Q-1:0]   slope_a_q [NSEG];

  logic signed [DSIZE:0] dm, dc;
  logic [DSIZE-1:0]      abs_dc;
  logic                  ge, last_bit;
  logic [Q-1:0]          quo_n, mag;
  logic signed [Q-1:0]   slope_fin;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dv_d        = dv_q;
    quo_d       = quo_q;
    neg_d       = neg_q;
    dpos_d      = dpos_q;
    cal_valid_d = cal_valid_q;
    dm          = $signed({1'b0, m_p_q[idx_q + 1'b1]}) - $signed({1'b0, m_p_q[idx_q]});
    dc          = $signed({1'b0, c_p_q[idx_q + 1'b1]}) - $signed({1'b0, c_p_q[idx_q]});
    abs_dc      = DSIZE'((dc < 0) ? -dc : dc);
    ge          = rem_q >= dv_q;
    quo_n       = {quo_q, ge};
    // A set top quotient bit means |slope| >= 2^(Q-1): clamp to the largest magnitude.
    mag         = quo_n[Q-1] ? {1'b0, {(Q-1){1'b1}}} : quo_n;
    slope_fin   = !dpos_q ? '0 : (neg_q ? $signed(-mag) : $signed(mag));
    last_bit    = cnt_q == CW'(Q - 1);
    case (state_q)
      S_IDLE: begin
        if (cal_begin) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        neg_d   = dc < 0;
        dpos_d  = dm > 0;
        rem_d   = RW'(abs_dc) << DT_D;
        dv_d    = (dm > 0) ? (RW'(dm[DSIZE-1:0]) << (Q - 1)) : '0;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = ge ? rem_q - dv_q : rem_q;
        dv_d  = dv_q >> 1;
        quo_d = quo_n[Q-2:0];
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          if (idx_q == SEG_LOG2'(NSEG - 2)) begin
            state_d = S_COMMIT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_COMMIT: begin
        cal_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      dv_q        <= '0;
      quo_q       <= '0;
      neg_q       <= 1'b0;
      dpos_q      <= 1'b0;
      cal_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dv_q        <= dv_d;
      quo_q       <= quo_d;
      neg_q       <= neg_d;
      dpos_q      <= dpos_d;
      cal_valid_q <= cal_valid_d;
    end
  end

  // Pending bank: host writes only while idle, slopes land as each divide finishes.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        m_p_q[i]     <= '0;
        c_p_q[i]     <= '0;
        slope_p_q[i] <= '0;
      end
    end else begin
      if (tbl_wr && state_q == S_IDLE) begin
        m_p_q[tbl_addr] <= tbl_m;
        c_p_q[tbl_addr] <= tbl_c;
      end
      if (state_q == S_DIV && last_bit) slope_p_q[idx_q] <= slope_fin;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        m_a_q[i]     <= '0;
        c_a_q[i]     <= '0;
        slope_a_q[i] <= '0;
      end
    end else if (state_q == S_COMMIT) begin
      for (int i = 0; i < NSEG; i++) begin
        m_a_q[i]     <= m_p_q[i];
        c_a_q[i]     <= c_p_q[i];
        slope_a_q[i] <= (i == NSEG - 1) ? '0 : slope_p_q[i];
      end
    end
  end

  // Streaming path has no backpressure: a sample is taken whenever in_valid is high
  // and emerges three cycles later with out_valid high; there is no ready.
  logic [SEG_LOG2-1:0]   seg1_d;
  logic [DSIZE-1:0]      off1_d;
  logic                  below;
  logic                  v1_q, v2_q, v3_q;
  logic [DSIZE-1:0]      off1_q, c1_q, c2_q, out_q, res_d;
  logic signed [Q-1:0]   sl1_q;
  logic signed [PW-1:0]  prod_d, prod2_q;
  logic signed [PW:0]    pr, sum;

  always_comb begin
    seg1_d = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (m_a_q[i] <= indata) seg1_d = SEG_LOG2'(i);
    end
    below = indata < m_a_q[0];
    if (below) seg1_d = '0;
    off1_d = below ? '0 : indata - m_a_q[seg1_d];
  end

  always_comb begin
    prod_d = PW'($signed({1'b0, off1_q})) * PW'(sl1_q);
    pr     = (PW+1)'(prod2_q) + RND;
    sum    = (pr >>> DT_D) + $signed((PW+1)'(c2_q));
    if (sum < 0)             res_d = '0;
    else if (sum > SUM_MAX)  res_d = '1;
    else                     res_d = sum[DSIZE-1:0];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      off1_q  <= '0;
      c1_q    <= '0;
      sl1_q   <= '0;
      c2_q    <= '0;
      prod2_q <= '0;
      out_q   <= '0;
    end else begin
      v1_q    <= in_valid;
      off1_q  <= off1_d;
      c1_q    <= c_a_q[seg1_d];
      sl1_q   <= slope_a_q[seg1_d];
      v2_q    <= v1_q;
      c2_q    <= c1_q;
      prod2_q <= prod_d;
      v3_q    <= v2_q;
      out_q   <= res_d;
    end
  end

  assign cal_busy  = state_q != S_IDLE;
  assign cal_valid = cal_valid_q;
  assign out_valid = v3_q;
  assign outdata   = out_q;

endmodule

// File: tb/tb_pwl_transform_engine.sv
// Directed self-checking bench for pwl_transform_engine: calibration timing, slopes,
// mapping, streaming across a commit, reset abort and the optional rounding mode.
module tb_pwl_transform_engine;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        tbl_wr;
  logic [3:0]  tbl_addr;
  logic [11:0] tbl_m, tbl_c;
  logic        cal_begin;
  logic        cal_busy, cal_valid;
  logic        in_valid;
  logic [11:0] indata;
  logic        out_valid;
  logic [11:0] outdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [11:0] exp_q[$];
  int          t_q[$];
  int          tm[16], tc[16];
  logic [11:0] mon_e;
  int          mon_t;
  int          ncyc, c0;

`ifdef PWL_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  pwl_transform_engine dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .tbl_wr    (tbl_wr),
    .tbl_addr  (tbl_addr),
    .tbl_m     (tbl_m),
    .tbl_c     (tbl_c),
    .cal_begin (cal_begin),
    .cal_busy  (cal_busy),
    .cal_valid (cal_valid),
    .in_valid  (in_valid),
    .indata    (indata),
    .out_valid (out_valid),
    .outdata   (outdata)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_valid", int'(out_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = t_q.pop_front();
        check("outdata", int'(outdata), int'(mon_e));
        check("latency", cyc - mon_t, 3);
      end
    end
  end

  // driver tasks
  task automatic wr(input int a, input int m, input int c);
    tbl_wr   = 1'b1;
    tbl_addr = 4'(a);
    tbl_m    = 12'(m);
    tbl_c    = 12'(c);
    @(negedge clock);
    tbl_wr = 1'b0;
  endtask

  task automatic load_tbl();
    for (int i = 0; i < 16; i++) wr(i, tm[i], tc[i]);
  endtask

  task automatic run_cal(output int n);
    n = 0;
    cal_begin = 1'b1;
    @(negedge clock);
    cal_begin = 1'b0;
    for (int k = 0; k < 1000 && cal_busy; k++) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic send(input int x, input int e);
    in_valid = 1'b1;
    indata   = 12'(x);
    exp_q.push_back(12'(e));
    t_q.push_back(cyc);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clock);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; tbl_wr = 1'b0; tbl_addr = '0; tbl_m = '0; tbl_c = '0;
    cal_begin = 1'b0; in_valid = 1'b0; indata = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", int'(cal_busy), 0);
    check("rst_cal_valid", int'(cal_valid), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_outdata", int'(outdata), 0);
    rst_n = 1'b1;
    @(negedge clock);

    // zero bank before any commit
    send(1234, 0);
    drain();

    // identity calibration
    for (int i = 0; i < 16; i++) begin tm[i] = 16 * i; tc[i] = 16 * i; end
    load_tbl();
    run_cal(ncyc);
    check("cal_cycles", ncyc, 196);
    check("cal_valid", int'(cal_valid), 1);
    for (int i = 0; i < 16; i++) check("id_slope", int'(dut.slope_a_q[i]), (i == 15) ? 0 : 16);
    send(40, 40);
    send(300, 240);
    send(100, 100);
    send(0, 0);
    drain();

    // streaming ramp across a commit to doubled C; tbl_wr while busy must be dropped
    for (int i = 0; i < 16; i++) wr(i, 16 * i, 32 * i);
    c0 = cyc;
    cal_begin = 1'b1;
    @(negedge clock);
    cal_begin = 1'b0;
    for (int k = 0; k < 256; k++) begin
      in_valid = 1'b1;
      indata   = 12'(k);
      if (k == 20) begin
        tbl_wr = 1'b1; tbl_addr = 4'd5; tbl_m = 12'd70; tbl_c = 12'd999;
      end else begin
        tbl_wr = 1'b0;
      end
      if (cyc > c0 + 196) exp_q.push_back(12'((k < 240) ? 2 * k : 480));
      else                exp_q.push_back(12'((k < 240) ? k : 240));
      t_q.push_back(cyc);
      @(negedge clock);
    end
    in_valid = 1'b0;
    tbl_wr   = 1'b0;
    check("stream_busy_done", int'(cal_busy), 0);
    check("stream_slope12", int'(dut.slope_a_q[12]), 32);
    drain();
    send(85, 170);
    drain();

    // negative slope
    for (int i = 0; i < 16; i++) begin tm[i] = 16 * i; tc[i] = 0; end
    tc[0] = 32;
    load_tbl();
    run_cal(ncyc);
    check("neg_slope0", int'(dut.slope_a_q[0]), -32);
    send(8, 16);
    send(4, 24);
    drain();
    wr(0, 0, 0);
    run_cal(ncyc);
    check("flat_slope0", int'(dut.slope_a_q[0]), 0);
    send(8, 0);
    drain();

    // saturation and degenerate segments
    tm[0] = 0;  tc[0] = 0;
    tm[1] = 1;  tc[1] = 4095;
    tm[2] = 2;  tc[2] = 0;
    tm[3] = 80; tc[3] = 0;
    tm[4] = 80; tc[4] = 100;
    for (int i = 5; i < 14; i++) begin tm[i] = 1000 + i; tc[i] = 100; end
    tm[14] = 4094; tc[14] = 0;
    tm[15] = 4095; tc[15] = 4095;
    load_tbl();
    run_cal(ncyc);
    check("sat_pos_slope0", int'(dut.slope_a_q[0]), 2047);
    check("sat_neg_slope1", int'(dut.slope_a_q[1]), -2047);
    check("equal_bp_slope3", int'(dut.slope_a_q[3]), 0);
    check("sat_pos_slope14", int'(dut.slope_a_q[14]), 2047);
    send(4095, 4095);
    send(4094, 0);
    send(80, 100);
    send(1, 4095);
    drain();

    // below first breakpoint
    for (int i = 0; i < 16; i++) begin tm[i] = 100 + 16 * i; tc[i] = 500 + 16 * i; end
    load_tbl();
    run_cal(ncyc);
    send(50, 500);
    send(99, 500);
    send(110, 510);
    drain();

    // fractional slope 1.5: truncation vs round-half-up
    for (int i = 0; i < 16; i++) begin tm[i] = 16 * i; tc[i] = 24; end
    tc[0] = 0;
    load_tbl();
    run_cal(ncyc);
    check("frac_slope0", int'(dut.slope_a_q[0]), 24);
    send(1, ROUND ? 2 : 1);
    send(3, ROUND ? 5 : 4);
    send(2, 3);
    send(16, 24);
    drain();

    // reset in the middle of a calculation
    cal_begin = 1'b1;
    @(negedge clock);
    cal_begin = 1'b0;
    repeat (49) @(negedge clock);
    check("mid_cal_busy", int'(cal_busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(cal_busy), 0);
    check("abort_cal_valid", int'(cal_valid), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_outdata", int'(outdata), 0);
    check("abort_slope0", int'(dut.slope_a_q[0]), 0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    send(16, 0);
    drain();
    run_cal(ncyc);
    check("post_rst_cycles", ncyc, 196);
    check("post_rst_cal_valid", int'(cal_valid), 1);
    send(1000, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
